// File: rtl/cdb_scheduler.sv
// ---------------------------------------------------------------------------
// cdb_scheduler
//
// Arbitrates the single Common Data Bus among NUM_REQ result producers
// (FP adder, FP multiplier, load unit). At most one requester is granted
// per cycle. The winner's tag and data are registered onto the CDB, so a
// grant in cycle N is broadcast in cycle N+1 for exactly one cycle.
//
// There are two arbitration modes:
//   mode = 0 : round-robin, starting the scan at rr_ptr.
//   mode = 1 : fixed priority (index 0 highest). A requester that has waited
//              STARVE_LIMIT cycles overrides the fixed order. If several
//              are starved, the lowest starved index wins.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset; also forces req_grant to 0
//   mode       0 = round-robin, 1 = fixed priority with aging
//   req_valid  per-requester "result pending"
//   req_tag    packed tags; requester i is at [i*TAG_WIDTH +: TAG_WIDTH]
//   req_data   packed results, packed the same way
//   req_grant  one-hot or zero; combinational, in the selection cycle
//   cdb_valid  registered broadcast strobe
//   cdb_tag    registered broadcast tag (holds when no broadcast)
//   cdb_data   registered broadcast data (holds when no broadcast)
//   grant_idx  registered index of the requester now on the CDB
//   err_tag    sticky flag: some requester asserted req_valid with tag 0
// ---------------------------------------------------------------------------
module cdb_scheduler #(
    parameter int NUM_REQ      = 3,
    parameter int TAG_WIDTH    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mode,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_grant,
    output logic                            cdb_valid,
    output logic [TAG_WIDTH-1:0]            cdb_tag,
    output logic [DATA_WIDTH-1:0]           cdb_data,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            err_tag
);

    // The wait counter must be able to hold STARVE_LIMIT itself (saturation).
    localparam int                CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_C  = CNT_W'(STARVE_LIMIT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [TAG_WIDTH-1:0]  tag_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    bad_tag;
    logic [NUM_REQ-1:0]    starved;

    logic                  sel_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      scan_idx;

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      wait_cnt_q [NUM_REQ];
    logic [CNT_W-1:0]      wait_cnt_d [NUM_REQ];
    logic                  cdb_valid_q, cdb_valid_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic                  err_tag_q, err_tag_d;

    // Per-requester unpacking and classification. Tag 0 means "no tag",
    // so a valid request carrying it can never be granted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign tag_arr[gi]   = req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
            assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign eligible[gi]  = req_valid[gi] && (tag_arr[gi] != '0);
            assign bad_tag[gi]   = req_valid[gi] && (tag_arr[gi] == '0);
            assign starved[gi]   = eligible[gi] && (wait_cnt_q[gi] >= LIMIT_C);
            assign req_grant[gi] = sel_valid && (sel_idx == IDX_W'(gi));
        end
    endgenerate

    // Winner selection from registered rr_ptr / wait counters.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        if (mode == 1'b0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                // rr_ptr_q and k are both below NUM_REQ, so one wrap suffices.
                if (int'(rr_ptr_q) + k >= NUM_REQ) begin
                    scan_idx = IDX_W'(int'(rr_ptr_q) + k - NUM_REQ);
                end else begin
                    scan_idx = IDX_W'(int'(rr_ptr_q) + k);
                end
                if (!sel_valid && eligible[scan_idx]) begin
                    sel_valid = 1'b1;
                    sel_idx   = scan_idx;
                end
            end
        end else begin
            // Starved requesters first, lowest index among them.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!sel_valid && starved[i]) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!sel_valid && eligible[i]) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end
        // No grant may be issued while reset is asserted.
        if (rst) begin
            sel_valid = 1'b0;
        end
    end

    // Next-state computation for the broadcast register and bookkeeping.
    always_comb begin
        cdb_valid_d = sel_valid;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        err_tag_d   = err_tag_q | (|bad_tag);

        if (sel_valid) begin
            cdb_tag_d   = tag_arr[sel_idx];
            cdb_data_d  = data_arr[sel_idx];
            grant_idx_d = sel_idx;
            rr_ptr_d    = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
        end

        // Aging: reset on grant or withdrawal, count up while passed over.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_grant[i] || !req_valid[i]) begin
                wait_cnt_d[i] = '0;
            end else if (eligible[i] && (wait_cnt_q[i] < LIMIT_C)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
            end else begin
                wait_cnt_d[i] = wait_cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            grant_idx_q <= '0;
            err_tag_q   <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            grant_idx_q <= grant_idx_d;
            err_tag_q   <= err_tag_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign grant_idx = grant_idx_q;
    assign err_tag   = err_tag_q;

endmodule

// File: tb/tb_cdb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cdb_scheduler
//
// Directed scenarios followed by randomized traffic. A behavioural model
// (plain integers, one pass over the arbitration rules per cycle) predicts
// each grant; every predicted grant pushes the expected broadcast into a
// queue that a separate negedge monitor pops whenever cdb_valid is seen.
// ---------------------------------------------------------------------------
module tb_cdb_scheduler;

    localparam int NUM_REQ      = 3;
    localparam int TAG_WIDTH    = 4;
    localparam int DATA_WIDTH   = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int IDX_W        = 2;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          mode = 1'b0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]            req_grant;
    logic                          cdb_valid;
    logic [TAG_WIDTH-1:0]          cdb_tag;
    logic [DATA_WIDTH-1:0]         cdb_data;
    logic [IDX_W-1:0]              grant_idx;
    logic                          err_tag;

    cdb_scheduler #(
        .NUM_REQ(NUM_REQ), .TAG_WIDTH(TAG_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_grant(req_grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .grant_idx(grant_idx), .err_tag(err_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
        logic [IDX_W-1:0]      idx;
    } bcast_t;

    bcast_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int                    m_rr = 0;
    int                    m_wait [NUM_REQ] = '{default: 0};
    bit                    m_err = 1'b0;
    int                    m_last_grant = -1;
    logic [TAG_WIDTH-1:0]  m_tag = '0;
    logic [DATA_WIDTH-1:0] m_data = '0;
    logic [IDX_W-1:0]      m_idx = '0;

    function automatic bit elig(int i);
        return req_valid[i] && (req_tag[i*TAG_WIDTH +: TAG_WIDTH] != '0);
    endfunction

    // Returns the index that should be granted now, or -1 for none.
    function automatic int ref_select();
        if (rst) return -1;
        if (mode == 1'b0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (elig((m_rr + k) % NUM_REQ)) return (m_rr + k) % NUM_REQ;
            end
            return -1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (elig(i) && m_wait[i] >= STARVE_LIMIT) return i;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (elig(i)) return i;
        end
        return -1;
    endfunction

    // Model update at each edge; pushes the expected broadcast on a grant.
    always @(posedge clk) begin
        int g;
        bcast_t b;
        g = ref_select();
        if (rst) begin
            m_rr = 0;
            for (int i = 0; i < NUM_REQ; i++) m_wait[i] = 0;
            m_err = 1'b0;
            m_tag = '0;
            m_data = '0;
            m_idx = '0;
            m_last_grant = -1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_tag[i*TAG_WIDTH +: TAG_WIDTH] == '0) m_err = 1'b1;
                if (g == i || !req_valid[i]) m_wait[i] = 0;
                else if (elig(i) && m_wait[i] < STARVE_LIMIT) m_wait[i] = m_wait[i] + 1;
            end
            if (g >= 0) begin
                b.tag  = req_tag[g*TAG_WIDTH +: TAG_WIDTH];
                b.data = req_data[g*DATA_WIDTH +: DATA_WIDTH];
                b.idx  = IDX_W'(g);
                exp_q.push_back(b);
                m_tag  = b.tag;
                m_data = b.data;
                m_idx  = b.idx;
                m_rr   = (g + 1) % NUM_REQ;
            end
            m_last_grant = g;
        end
    end

    // Monitor: compares grant, broadcast and error flag away from the edge.
    always @(negedge clk) begin
        int eg;
        logic [NUM_REQ-1:0] exp_grant;
        bcast_t b;
        eg = ref_select();
        exp_grant = (eg >= 0) ? NUM_REQ'(1 << eg) : '0;
        vectors++;
        if (req_grant !== exp_grant) begin
            miscompares++;
            $display("FAIL req_grant t=%0t got %b expected %b", $time, req_grant, exp_grant);
        end
        vectors++;
        if (cdb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL cdb_unexpected t=%0t got valid tag %0d expected no broadcast", $time, cdb_tag);
            end else begin
                b = exp_q.pop_front();
                if (cdb_tag !== b.tag || cdb_data !== b.data || grant_idx !== b.idx) begin
                    miscompares++;
                    $display("FAIL cdb_bcast t=%0t got tag %0d data %h idx %0d expected tag %0d data %h idx %0d",
                             $time, cdb_tag, cdb_data, grant_idx, b.tag, b.data, b.idx);
                end
            end
        end else if (cdb_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL cdb_missing t=%0t got valid %b expected valid with %0d queued",
                     $time, cdb_valid, exp_q.size());
            exp_q.delete();
        end else if (cdb_tag !== m_tag || cdb_data !== m_data || grant_idx !== m_idx) begin
            miscompares++;
            $display("FAIL cdb_hold t=%0t got tag %0d data %h idx %0d expected tag %0d data %h idx %0d",
                     $time, cdb_tag, cdb_data, grant_idx, m_tag, m_data, m_idx);
        end
        vectors++;
        if (err_tag !== m_err) begin
            miscompares++;
            $display("FAIL err_tag t=%0t got %b expected %b", $time, err_tag, m_err);
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, got, want);
        end
    endtask

    // One cycle of stimulus; exp_g >= -1 additionally checks req_grant
    // against a hand-derived constant (-1 = no grant, -2 = skip).
    task automatic cyc(input logic r, input logic m, input logic [NUM_REQ-1:0] v,
                       input logic [NUM_REQ*TAG_WIDTH-1:0] t,
                       input logic [NUM_REQ*DATA_WIDTH-1:0] d, input int exp_g);
        logic [NUM_REQ-1:0] want;
        rst = r; mode = m; req_valid = v; req_tag = t; req_data = d;
        #3;
        if (exp_g >= -1) begin
            want = (exp_g >= 0) ? NUM_REQ'(1 << exp_g) : '0;
            vectors++;
            if (req_grant !== want) begin
                miscompares++;
                $display("FAIL directed_grant t=%0t got %b expected %b", $time, req_grant, want);
            end
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [NUM_REQ*TAG_WIDTH-1:0]  TAGS_123 = {4'd3, 4'd2, 4'd1};
    localparam logic [NUM_REQ*DATA_WIDTH-1:0] DATA_123 = {32'h33, 32'h22, 32'h11};

    logic                  cur_v [NUM_REQ];
    logic [TAG_WIDTH-1:0]  cur_t [NUM_REQ];
    logic [DATA_WIDTH-1:0] cur_d [NUM_REQ];
    logic                  r_rst, r_mode;

    initial begin
        @(posedge clk);
        #1;
        // 1: reset holds grants at zero
        cyc(1'b1, 1'b0, 3'b111, TAGS_123, DATA_123, -1);
        cyc(1'b1, 1'b0, 3'b111, TAGS_123, DATA_123, -1);
        check_bit("reset_cdb_valid", cdb_valid, 1'b0);
        check_bit("reset_err_tag", err_tag, 1'b0);

        // 2: round-robin over three continuous requesters
        cyc(1'b0, 1'b0, 3'b111, TAGS_123, DATA_123, 0);
        cyc(1'b0, 1'b0, 3'b111, TAGS_123, DATA_123, 1);
        cyc(1'b0, 1'b0, 3'b111, TAGS_123, DATA_123, 2);
        cyc(1'b0, 1'b0, 3'b111, TAGS_123, DATA_123, 0);
        cyc(1'b0, 1'b0, 3'b111, TAGS_123, DATA_123, 1);
        check_bit("rr_cdb_valid_cont", cdb_valid, 1'b1);

        // 3: fixed priority with aging of req2
        cyc(1'b1, 1'b0, 3'b000, '0, '0, -1);
        cyc(1'b0, 1'b1, 3'b101, TAGS_123, DATA_123, 0);
        cyc(1'b0, 1'b1, 3'b101, TAGS_123, DATA_123, 0);
        cyc(1'b0, 1'b1, 3'b101, TAGS_123, DATA_123, 0);
        cyc(1'b0, 1'b1, 3'b101, TAGS_123, DATA_123, 0);
        cyc(1'b0, 1'b1, 3'b101, TAGS_123, DATA_123, 2);
        cyc(1'b0, 1'b1, 3'b101, TAGS_123, DATA_123, 0);

        // 4: tag-0 request from req1 is never granted, err_tag is sticky
        cyc(1'b0, 1'b1, 3'b011, {4'd3, 4'd0, 4'd1}, DATA_123, 0);
        check_bit("err_tag_set", err_tag, 1'b1);
        cyc(1'b0, 1'b1, 3'b011, {4'd3, 4'd0, 4'd1}, DATA_123, 0);
        cyc(1'b0, 1'b0, 3'b000, '0, '0, -1);
        check_bit("err_tag_sticky", err_tag, 1'b1);

        // 5: single requester with updated data each cycle
        cyc(1'b1, 1'b0, 3'b000, '0, '0, -1);
        cyc(1'b0, 1'b0, 3'b010, {4'd0, 4'd2, 4'd0}, {32'h0, 32'hA, 32'h0}, 1);
        cyc(1'b0, 1'b0, 3'b010, {4'd0, 4'd2, 4'd0}, {32'h0, 32'hB, 32'h0}, 1);
        cyc(1'b0, 1'b0, 3'b010, {4'd0, 4'd2, 4'd0}, {32'h0, 32'hC, 32'h0}, 1);

        // 6: reset right after a grant to req2
        cyc(1'b0, 1'b0, 3'b100, {4'd5, 4'd0, 4'd0}, {32'h55, 32'h0, 32'h0}, 2);
        check_bit("midrst_bcast_valid", cdb_valid, 1'b1);
        cyc(1'b1, 1'b0, 3'b001, {4'd0, 4'd0, 4'd1}, DATA_123, -1);
        check_bit("midrst_valid_dropped", cdb_valid, 1'b0);

        // Randomized traffic; an eligible request holds until it is granted.
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_v[i] = 1'b0; cur_t[i] = '0; cur_d[i] = '0;
        end
        r_mode = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(cur_v[i] && cur_t[i] != '0 && m_last_grant != i)) begin
                    cur_v[i] = ($urandom_range(0, 9) < 6);
                    cur_t[i] = TAG_WIDTH'($urandom_range(0, 15));
                    cur_d[i] = $urandom;
                end
            end
            if ($urandom_range(0, 19) == 0) r_mode = ~r_mode;
            r_rst = ($urandom_range(0, 49) == 0);
            cyc(r_rst, r_mode, {cur_v[2], cur_v[1], cur_v[0]},
                {cur_t[2], cur_t[1], cur_t[0]}, {cur_d[2], cur_d[1], cur_d[0]}, -2);
        end

        cyc(1'b0, 1'b0, 3'b000, '0, '0, -2);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
